// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous block RAM (one-cycle read latency) between
// the instruction-fetch requester and the data-access requester. At most one
// access is in flight. Each access takes three cycles:
//   IDLE (grant, drive RAM) -> ISSUE (RAM samples) -> WAIT_RD (capture, ack).
//
// Handshake: i_req/d_req are levels held until the matching one-cycle ack.
// The requester drops the request during its ack cycle. A request that is
// still high at the next IDLE sample starts a new access. Read data is held
// until the next ack of the same port. Write acks leave d_rdata unchanged.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (last_owner register).
//                  undefined -> fixed priority, data port over fetch port.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   i_req/i_addr             fetch request and byte address
//   i_ack/i_rdata            fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata data request, direction, byte address, write data
//   d_ack/d_rdata            data completion pulse and read word
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  block RAM interface
//   busy                     high whenever the FSM is not in IDLE
//   misalign                 pulses with the ack if addr[1:0] != 0
//   state_dbg                current FSM state (IDLE=0, ISSUE=1, WAIT_RD=2)
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              misalign,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]  state;
  logic        owner_d;   // 1 = data port owns the access, 0 = fetch port
  logic        we_q;      // access in flight is a write
  logic        mis_q;     // granted address was misaligned
  logic        grant_d;
  logic        grant_i;
  logic [31:0] sel_addr;

  // Address bits above the RAM word range are intentionally ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

`ifdef MEM_ARB_RR_EN
  logic last_owner;       // 1 = data port was granted last, 0 = fetch port
  // On a tie the port that was not granted last wins; single requests win.
  assign grant_d = d_req & (~i_req | ~last_owner);
`else
  assign grant_d = d_req;
`endif
  assign grant_i  = i_req & ~grant_d;
  assign sel_addr = grant_d ? d_addr : i_addr;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      misalign  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      // Acks and misalign are single-cycle pulses.
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner_d  <= grant_d;
            we_q     <= grant_d & d_we;
            mis_q    <= |sel_addr[1:0];
            ram_en   <= 1'b1;
            ram_we   <= grant_d & d_we;   // fetch port never writes
            ram_addr <= sel_addr[ADDR_W+1:2];
            if (grant_d) begin
              ram_wdata <= d_wdata;
            end
`ifdef MEM_ARB_RR_EN
            last_owner <= grant_d;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // RAM samples the command on this edge; read data follows next cycle.
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= WAIT_RD;
        end
        WAIT_RD: begin
          if (owner_d) begin
            if (!we_q) begin
              d_rdata <= ram_rdata;
            end
            d_ack <= 1'b1;
          end else begin
            i_rdata <= ram_rdata;
            i_ack   <= 1'b1;
          end
          misalign <= mis_q;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural block RAM, table-driven
// directed vectors, hand-written multi-cycle sequences (ties, held request,
// reset mid-access) and randomized accesses checked against a word-level
// memory model. Works with or without MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int WORDS  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              i_req, d_req, d_we;
  logic [31:0]       i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_ack, d_ack, ram_en, ram_we, busy, misalign;
  logic [DATA_W-1:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        state_dbg;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .misalign(misalign), .state_dbg(state_dbg)
  );

  // ---------------- behavioural block RAM ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h2010FFFF : (32'hC0DE0000 | 32'(i));
  endfunction

  logic [31:0] mem [0:WORDS-1];
  bit          written [0:WORDS-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] exp_i, exp_d;
  bit          model_last;      // 1 = data port granted last
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tie_winner_is_d();
`ifdef MEM_ARB_RR_EN
    return !model_last;
`else
    return 1'b1;
`endif
  endfunction

  // Model update for one completed access, from the memory-level rules.
  task automatic model_done(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    logic [9:0] idx;
    idx = addr[11:2];
    if (is_d && we) ref_mem[idx] = wdata;
    else if (is_d)  exp_d = ref_mem[idx];
    else            exp_i = ref_mem[idx];
    model_last = is_d;
  endtask

  // ---------------- driver: one complete access ----------------
  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] got,
                           output bit got_mis);
    logic [9:0] idx;
    int lat;
    idx = addr[11:2];
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("issue_en", 64'(ram_en), 64'(1));
        chk("issue_addr", 64'(ram_addr), 64'(idx));
        chk("issue_we", 64'(ram_we), 64'(is_d && we));
        chk("issue_busy", 64'(busy), 64'(1));
        if (is_d && we) chk("issue_wdata", 64'(ram_wdata), 64'(wdata));
      end
      if (c == 2) chk("en_one_cycle", 64'(ram_en), 64'(0));
      if (is_d ? d_ack : i_ack) begin
        lat = c;
        break;
      end
    end
    chk("ack_latency", 64'(lat), 64'(3));
    chk("other_ack", 64'(is_d ? i_ack : d_ack), 64'(0));
    chk("misalign", 64'(misalign), 64'(addr[1:0] != 2'b00));
    got     = is_d ? d_rdata : i_rdata;
    got_mis = misalign;
    model_done(is_d, we, addr, wdata);
    chk("i_rdata", 64'(i_rdata), 64'(exp_i));
    chk("d_rdata", 64'(d_rdata), 64'(exp_d));
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  // Both ports request on the same edge. With hold_loser the loser keeps its
  // request and must be served 3 cycles after the winner's ack.
  task automatic tie_round(input bit hold_loser);
    bit exp_d_first;
    int lat;
    int both;
    exp_d_first = tie_winner_is_d();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    lat = 0; both = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) both++;
      if (i_ack || d_ack) begin lat = c; break; end
    end
    chk("tie_latency", 64'(lat), 64'(3));
    chk("tie_winner_d", 64'(d_ack), 64'(exp_d_first));
    model_done(exp_d_first, 1'b0, exp_d_first ? 32'h14 : 32'h8, 32'h0);
    chk("tie_i_rdata", 64'(i_rdata), 64'(exp_i));
    chk("tie_d_rdata", 64'(d_rdata), 64'(exp_d));
    if (exp_d_first) d_req = 1'b0; else i_req = 1'b0;
    if (hold_loser) begin
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (i_ack && d_ack) both++;
        if (i_ack || d_ack) begin lat = c; break; end
      end
      chk("loser_latency", 64'(lat), 64'(3));
      chk("loser_d", 64'(d_ack), 64'(!exp_d_first));
      model_done(!exp_d_first, 1'b0, exp_d_first ? 32'h8 : 32'h14, 32'h0);
      chk("loser_i_rdata", 64'(i_rdata), 64'(exp_i));
      chk("loser_d_rdata", 64'(d_rdata), 64'(exp_d));
    end
    chk("acks_exclusive", 64'(both), 64'(0));
    i_req = 1'b0; d_req = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;   // checked for reads only
    bit          exp_mis;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] got;
    bit          got_mis;
    int          acks;
    int          lat;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          32'h2010FFFF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0014, 32'hDEADBEEF,   32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,          32'hC0DE0001, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_1008, 32'h0,          32'h2010FFFF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0016, 32'h0,          32'hDEADBEEF, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h12345678,   32'h0,        1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,          32'h12345678, 1'b0};

    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    exp_i = '0; exp_d = '0; model_last = 1'b0;

    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    chk("rst_ctrl", 64'({i_ack, d_ack, ram_en, ram_we, busy, misalign}), 64'(0));
    chk("rst_state", 64'(state_dbg), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven directed accesses.
    for (int v = 0; v < 8; v++) begin
      do_access(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, got, got_mis);
      if (!(vecs[v].is_d && vecs[v].we)) chk($sformatf("vec%0d_rdata", v), 64'(got), 64'(vecs[v].exp_rdata));
      chk($sformatf("vec%0d_mis", v), 64'(got_mis), 64'(vecs[v].exp_mis));
    end

    // Tie with loser held, then repeated clean ties.
    tie_round(1'b1);
    for (int r = 0; r < 4; r++) tie_round(1'b0);

    // Fetch request held through its ack: a second fetch follows 3 cycles later.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    acks = 0; lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (i_ack) begin
        acks++;
        if (acks == 2) begin lat = c; break; end
      end
    end
    i_req = 1'b0;
    chk("held_second_ack_cycle", 64'(lat), 64'(6));
    chk("held_rdata", 64'(i_rdata), 64'(32'h2010FFFF));
    model_done(1'b0, 1'b0, 32'h8, 32'h0);

    // Randomized accesses against the model.
    for (int n = 0; n < 40; n++) begin
      bit          rd;
      bit          rw;
      logic [31:0] ra;
      rd = 1'($urandom_range(0, 1));
      rw = rd & 1'($urandom_range(0, 1));
      ra = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      do_access(rd, rw, ra, $urandom, got, got_mis);
    end

    // Reset while a write is in ISSUE.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({i_ack, d_ack, ram_en, ram_we, busy, misalign}), 64'(0));
    chk("mid_rst_addr", 64'(ram_addr), 64'(0));
    chk("mid_rst_wdata", 64'(ram_wdata), 64'(0));
    chk("mid_rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_i = '0; exp_d = '0; model_last = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    chk("no_ack_after_reset", 64'(acks), 64'(0));
    do_access(1'b0, 1'b0, 32'h8, 32'h0, got, got_mis);
    chk("post_rst_fetch", 64'(got), 64'(32'h2010FFFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
